// File: rtl/spmv_row_accumulator_if.sv
// Handshake bundle between the SpMV product channel, the row accumulator and the writeback stage.
// The slave side is the accumulator; the master side is the producer/consumer around it.
interface spmv_row_accumulator_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 64,
  parameter int ROW_W  = 32
);
  logic                    in_val;
  logic                    in_rdy;
  logic [LANES*ROW_W-1:0]  in_row_id;
  logic [LANES*DATA_W-1:0] in_prod;
  logic [LANES-1:0]        in_mask;
  logic                    in_last;
  logic                    out_val;
  logic                    out_rdy;
  logic [ROW_W-1:0]        out_row_id;
  logic [DATA_W-1:0]       out_sum;
  logic                    out_ovf;
  logic                    done;
  logic                    err_order;

  modport master (
    output in_val, in_row_id, in_prod, in_mask, in_last, out_rdy,
    input  in_rdy, out_val, out_row_id, out_sum, out_ovf, done, err_order
  );

  modport slave (
    input  in_val, in_row_id, in_prod, in_mask, in_last, out_rdy,
    output in_rdy, out_val, out_row_id, out_sum, out_ovf, done, err_order
  );
endinterface

// File: rtl/spmv_row_accumulator.sv
// Sums consecutive same-row products one lane per cycle; a result appears the cycle after a row change.
// in_rdy only in IDLE; results hold under out_rdy=0. SPMV_ACC_OVF_DETECT_EN adds the per-row out_ovf flag.
module spmv_row_accumulator #(
  parameter int LANES  = 4,
  parameter int DATA_W = 64,
  parameter int ROW_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  spmv_row_accumulator_if.slave    bus
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, PROC, EMIT, FLUSH} state_t;

  state_t            state;
  logic [ROW_W-1:0]  row_buf  [LANES];
  logic [DATA_W-1:0] prod_buf [LANES];
  logic [LANES-1:0]  pend;
  logic              last_r;
  logic              have_row;
  logic [ROW_W-1:0]  cur_row;
  logic [DATA_W-1:0] acc;
  logic              out_val_r;
  logic              done_r;
  logic              err_r;

  logic [LW-1:0]     sel;
  logic [LANES-1:0]  pend_next;
  logic [ROW_W-1:0]  row_l;
  logic [DATA_W-1:0] prod_l;
  logic [DATA_W-1:0] sum;

  // Lowest pending lane is always the next one consumed.
  always_comb begin
    sel = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend[i]) sel = LW'(i);
    end
  end

  assign pend_next = pend & ~(LANES'(1) << sel);
  assign row_l     = row_buf[sel];
  assign prod_l    = prod_buf[sel];
  assign sum       = acc + prod_l;

`ifdef SPMV_ACC_OVF_DETECT_EN
  logic ovf_r;
  logic add_ovf;
  assign add_ovf     = (acc[DATA_W-1] == prod_l[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]);
  assign bus.out_ovf = ovf_r;
`else
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.in_rdy     = (state == IDLE);
  assign bus.out_val    = out_val_r;
  assign bus.out_row_id = cur_row;
  assign bus.out_sum    = acc;
  assign bus.done       = done_r;
  assign bus.err_order  = err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      last_r    <= 1'b0;
      have_row  <= 1'b0;
      cur_row   <= '0;
      acc       <= '0;
      out_val_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        row_buf[i]  <= '0;
        prod_buf[i] <= '0;
      end
`ifdef SPMV_ACC_OVF_DETECT_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_val) begin
            for (int i = 0; i < LANES; i++) begin
              row_buf[i]  <= bus.in_row_id[i*ROW_W +: ROW_W];
              prod_buf[i] <= bus.in_prod[i*DATA_W +: DATA_W];
            end
            pend   <= bus.in_mask;
            last_r <= bus.in_last;
            if (|bus.in_mask) begin
              state <= PROC;
            end else if (bus.in_last) begin
              // A row still open from earlier beats is flushed; otherwise FLUSH only pulses done.
              state     <= FLUSH;
              out_val_r <= have_row;
            end
          end
        end

        PROC: begin
          if (!have_row || row_l == cur_row) begin
            if (!have_row) begin
              cur_row  <= row_l;
              acc      <= prod_l;
              have_row <= 1'b1;
`ifdef SPMV_ACC_OVF_DETECT_EN
              ovf_r    <= 1'b0;
`endif
            end else begin
              acc      <= sum;
`ifdef SPMV_ACC_OVF_DETECT_EN
              ovf_r    <= ovf_r | add_ovf;
`endif
            end
            pend <= pend_next;
            if (pend_next == '0) begin
              if (last_r) begin
                state     <= FLUSH;
                out_val_r <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end else begin
            if (row_l < cur_row) err_r <= 1'b1;
            state     <= EMIT;
            out_val_r <= 1'b1;
          end
        end

        EMIT: begin
          if (bus.out_rdy) begin
            cur_row <= row_l;
            acc     <= prod_l;
            pend    <= pend_next;
`ifdef SPMV_ACC_OVF_DETECT_EN
            ovf_r   <= 1'b0;
`endif
            if (pend_next != '0) begin
              state     <= PROC;
              out_val_r <= 1'b0;
            end else if (last_r) begin
              // The freshly loaded row is the final one; out_val stays up to present it.
              state <= FLUSH;
            end else begin
              state     <= IDLE;
              out_val_r <= 1'b0;
            end
          end
        end

        FLUSH: begin
          if (!out_val_r) begin
            done_r <= 1'b1;
            state  <= IDLE;
          end else if (bus.out_rdy) begin
            out_val_r <= 1'b0;
            have_row  <= 1'b0;
            done_r    <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Scoreboard bench for spmv_row_accumulator: a behavioural row model queues expected results per beat,
// and a negedge monitor compares every presented result against the queue head.
module tb_spmv_row_accumulator;
  localparam int LANES  = 4;
  localparam int DATA_W = 64;
  localparam int ROW_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spmv_row_accumulator_if #(.LANES(LANES), .DATA_W(DATA_W), .ROW_W(ROW_W)) bus ();

  spmv_row_accumulator #(.LANES(LANES), .DATA_W(DATA_W), .ROW_W(ROW_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] sum;
    logic              ovf;
  } res_t;

  res_t              exp_q[$];
  int                vec_cnt = 0;
  int                err_cnt = 0;
  logic              m_have = 1'b0;
  logic              m_ovf  = 1'b0;
  logic              m_err  = 1'b0;
  logic [ROW_W-1:0]  m_row  = '0;
  logic [DATA_W-1:0] m_acc  = '0;
  int                lat, low;
  logic              saw;
  logic              rnd_on;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_res();
    res_t r;
    r.row = m_row;
    r.sum = m_acc;
    r.ovf = m_ovf;
    exp_q.push_back(r);
  endtask

  task automatic model_beat(input logic [LANES*ROW_W-1:0] rows, input logic [LANES*DATA_W-1:0] prods,
                            input logic [LANES-1:0] mask, input logic last);
    logic [ROW_W-1:0]  r;
    logic [DATA_W-1:0] p, s;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        r = rows[i*ROW_W +: ROW_W];
        p = prods[i*DATA_W +: DATA_W];
        if (!m_have) begin
          m_have = 1'b1; m_row = r; m_acc = p; m_ovf = 1'b0;
        end else if (r == m_row) begin
          s = m_acc + p;
`ifdef SPMV_ACC_OVF_DETECT_EN
          if (m_acc[DATA_W-1] == p[DATA_W-1] && s[DATA_W-1] != m_acc[DATA_W-1]) m_ovf = 1'b1;
`endif
          m_acc = s;
        end else begin
          if (r < m_row) m_err = 1'b1;
          push_res();
          m_row = r; m_acc = p; m_ovf = 1'b0;
        end
      end
    end
    if (last && m_have) begin
      push_res();
      m_have = 1'b0;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [LANES*ROW_W-1:0] rows, input logic [LANES*DATA_W-1:0] prods,
                      input logic [LANES-1:0] mask, input logic last);
    int n;
    model_beat(rows, prods, mask, last);
    bus.in_row_id = rows;
    bus.in_prod   = prods;
    bus.in_mask   = mask;
    bus.in_last   = last;
    bus.in_val    = 1'b1;
    n = 0;
    while (!bus.in_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("in_rdy_timeout", 64'(bus.in_rdy), 64'd1);
    @(posedge clk); #1;
    bus.in_val = 1'b0;
  endtask

  task automatic wait_done(output int lat_o, output int low_o, output logic saw_o);
    lat_o = 0; low_o = 0; saw_o = 1'b0;
    while (lat_o < 300) begin
      @(negedge clk);
      lat_o++;
      if (bus.out_val) saw_o = 1'b1;
      else if (!bus.in_rdy) low_o++;
      if (bus.done) break;
    end
    if (!bus.done) check("done_timeout", 64'(bus.done), 64'd1);
    @(negedge clk);
    check("done_pulse_width", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_rdy"},  64'(bus.in_rdy),     64'd1);
    check({tag, "_out_val"}, 64'(bus.out_val),    64'd0);
    check({tag, "_done"},    64'(bus.done),       64'd0);
    check({tag, "_err"},     64'(bus.err_order),  64'd0);
    check({tag, "_row"},     64'(bus.out_row_id), 64'd0);
    check({tag, "_sum"},     64'(bus.out_sum),    64'd0);
    check({tag, "_ovf"},     64'(bus.out_ovf),    64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_val) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(bus.out_val), 64'd0);
      end else begin
        check("res_row", 64'(bus.out_row_id), 64'(exp_q[0].row));
        check("res_sum", 64'(bus.out_sum),    64'(exp_q[0].sum));
        check("res_ovf", 64'(bus.out_ovf),    64'(exp_q[0].ovf));
        check("busy_in_rdy", 64'(bus.in_rdy), 64'd0);
        if (bus.out_rdy) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [ROW_W-1:0]        rr;
    logic [LANES*ROW_W-1:0]  rv;
    logic [LANES*DATA_W-1:0] pv;
    logic [LANES-1:0]        mv;
    int                      n;

    bus.in_val = 1'b0; bus.in_row_id = '0; bus.in_prod = '0;
    bus.in_mask = '0; bus.in_last = 1'b0; bus.out_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single full beat, one row.
    send({32'd5, 32'd5, 32'd5, 32'd5}, {64'd4, 64'd3, 64'd2, 64'd1}, 4'b1111, 1'b1);
    wait_done(lat, low, saw);
    check("t1_done_latency", 64'(lat), 64'd6);
    check("t1_proc_cycles",  64'(low), 64'd4);
    check("t1_drained",      64'(exp_q.size()), 64'd0);

    // Row spanning two beats.
    send({32'd1, 32'd1, 32'd0, 32'd0}, {64'd1, 64'd1, 64'd1, 64'd1}, 4'b1111, 1'b0);
    send({32'd2, 32'd2, 32'd2, 32'd1}, {64'd1, 64'd1, 64'd1, 64'd1}, 4'b1111, 1'b1);
    wait_done(lat, low, saw);
    check("t2_err_order", 64'(bus.err_order), 64'(m_err));
    check("t2_drained",   64'(exp_q.size()), 64'd0);

    // Output backpressure for 10 cycles.
    bus.out_rdy = 1'b0;
    send({32'd4, 32'd4, 32'd3, 32'd3}, {64'd40, 64'd30, 64'd20, 64'd10}, 4'b1111, 1'b1);
    n = 0;
    while (!bus.out_val && n < 50) begin @(negedge clk); n++; end
    check("t3_out_val_seen", 64'(bus.out_val), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("t3_hold_val",    64'(bus.out_val), 64'd1);
      check("t3_hold_in_rdy", 64'(bus.in_rdy),  64'd0);
    end
    @(posedge clk); #1;
    bus.out_rdy = 1'b1;
    wait_done(lat, low, saw);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // Masked lanes, then an empty last beat with no open row.
    send({32'd9, 32'd99, 32'd7, 32'd99}, {64'd8, 64'd555, -64'd3, 64'd555}, 4'b1010, 1'b1);
    wait_done(lat, low, saw);
    check("t4_drained", 64'(exp_q.size()), 64'd0);
    send('0, '0, 4'b0000, 1'b1);
    wait_done(lat, low, saw);
    check("t4_empty_no_out",  64'(saw), 64'd0);
    check("t4_empty_latency", 64'(lat), 64'd2);

    // Decreasing row ID.
    send({32'd0, 32'd0, 32'd3, 32'd4}, {64'd0, 64'd0, 64'd22, 64'd11}, 4'b0011, 1'b1);
    wait_done(lat, low, saw);
    check("t5_err_order", 64'(bus.err_order), 64'(m_err));
    check("t5_drained",   64'(exp_q.size()), 64'd0);

    // Reset in the middle of PROC discards the partial row.
    send({32'd8, 32'd8, 32'd8, 32'd8}, {64'd100, 64'd100, 64'd100, 64'd100}, 4'b1111, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    check("midrst_queue", 64'(exp_q.size()), 64'd0);
    m_have = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send({32'd0, 32'd0, 32'd8, 32'd8}, {64'd0, 64'd0, 64'd2, 64'd1}, 4'b0011, 1'b1);
    wait_done(lat, low, saw);
    check("t6_drained", 64'(exp_q.size()), 64'd0);

`ifdef SPMV_ACC_OVF_DETECT_EN
    send({32'd0, 32'd7, 32'd6, 32'd6}, {64'd0, 64'd5, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF}, 4'b0111, 1'b1);
    wait_done(lat, low, saw);
    check("t7_drained", 64'(exp_q.size()), 64'd0);
`endif

    // Random beats with random output backpressure.
    rr = 32'd100;
    rnd_on = 1'b1;
    fork
      begin
        for (int b = 0; b < 12; b++) begin
          for (int i = 0; i < LANES; i++) begin
            rv[i*ROW_W +: ROW_W]   = rr;
            pv[i*DATA_W +: DATA_W] = {$urandom, $urandom};
            rr = rr + 32'($urandom_range(0, 1));
          end
          mv = (b == 11) ? 4'b1111 : 4'($urandom_range(0, 15));
          send(rv, pv, mv, (b == 11));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          bus.out_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_rdy = 1'b1;
    wait_done(lat, low, saw);
    check("rnd_err_order", 64'(bus.err_order), 64'(m_err));
    check("rnd_drained",   64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
